// File: rtl/bsg_dmc_ui_burst_adapter.sv
// Whole-burst request front end for the DMC app_* interface: serializes write bursts, reassembles read bursts.
// Optional macro BSG_DMC_UI_BURST_ADAPTER_WDATA_FIRST_EN sends write data beats before the write command.
module bsg_dmc_ui_burst_adapter #(
    parameter int ui_addr_width_p   = 28,
    parameter int ui_data_width_p   = 32,
    parameter int ui_burst_length_p = 8,
    parameter int rd_fifo_els_p     = 4,
    localparam int burst_width_lp   = ui_data_width_p * ui_burst_length_p,
    localparam int mask_width_lp    = burst_width_lp / 8,
    localparam int beat_mask_w_lp   = ui_data_width_p / 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       init_calib_complete_i,
    input  logic                       cmd_v_i,
    output logic                       cmd_ready_o,
    input  logic                       cmd_write_i,
    input  logic [ui_addr_width_p-1:0] cmd_addr_i,
    input  logic [burst_width_lp-1:0]  cmd_data_i,
    input  logic [mask_width_lp-1:0]   cmd_mask_i,
    output logic                       rd_v_o,
    output logic [burst_width_lp-1:0]  rd_data_o,
    input  logic                       rd_yumi_i,
    output logic [ui_addr_width_p-1:0] app_addr_o,
    output logic [2:0]                 app_cmd_o,
    output logic                       app_en_o,
    input  logic                       app_rdy_i,
    output logic                       app_wdf_wren_o,
    output logic [ui_data_width_p-1:0] app_wdf_data_o,
    output logic [beat_mask_w_lp-1:0]  app_wdf_mask_o,
    output logic                       app_wdf_end_o,
    input  logic                       app_wdf_rdy_i,
    input  logic                       app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0] app_rd_data_i,
    input  logic                       app_rd_data_end_i,
    output logic                       error_o
);

    localparam int beat_w_lp = (ui_burst_length_p > 1) ? $clog2(ui_burst_length_p) : 1;
    localparam int cred_w_lp = $clog2(rd_fifo_els_p + 1);
    localparam int ptr_w_lp  = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
    localparam logic [beat_w_lp-1:0] last_beat_lp   = beat_w_lp'(ui_burst_length_p - 1);
    localparam logic [cred_w_lp-1:0] max_credits_lp = cred_w_lp'(rd_fifo_els_p);
    localparam logic [ptr_w_lp-1:0]  last_ptr_lp    = ptr_w_lp'(rd_fifo_els_p - 1);
    localparam logic [2:0] app_write_lp = 3'b000;
    localparam logic [2:0] app_read_lp  = 3'b001;

    typedef enum logic [1:0] {IDLE, CMD, WDATA} state_e;

    state_e                       state_r, state_n;
    logic [ui_addr_width_p-1:0]   addr_r;
    logic [2:0]                   cmd_r;
    logic [burst_width_lp-1:0]    data_r;
    logic [mask_width_lp-1:0]     mask_r;
    logic [beat_w_lp-1:0]         wbeat_r;
    logic [cred_w_lp-1:0]         credits_r;
    logic [cred_w_lp-1:0]         outstanding_r;
    logic [beat_w_lp-1:0]         rbeat_r;
    logic [burst_width_lp-1:0]    asm_r;
    logic [burst_width_lp-1:0]    push_data;
    logic [burst_width_lp-1:0]    mem [rd_fifo_els_p];
    logic [ptr_w_lp-1:0]          wptr_r, rptr_r;
    logic [cred_w_lp-1:0]         count_r;
    logic                         error_r;

    logic accept, read_issue, wdf_hs, pop, beat_last, push, fifo_full, fifo_write, err_cond;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    assign accept     = cmd_v_i & cmd_ready_o;
    assign read_issue = (state_r == CMD) & app_rdy_i & (cmd_r == app_read_lp);
    assign wdf_hs     = app_wdf_wren_o & app_wdf_rdy_i;
    assign pop        = rd_yumi_i & rd_v_o;
    assign beat_last  = (rbeat_r == last_beat_lp);
    assign push       = app_rd_data_valid_i & beat_last;
    assign fifo_full  = (count_r == max_credits_lp);
    assign fifo_write = push & ~fifo_full;
    assign err_cond   = (app_rd_data_valid_i & ((app_rd_data_end_i != beat_last) | (outstanding_r == '0)))
                      | (push & fifo_full);

    assign app_addr_o     = addr_r;
    assign app_cmd_o      = cmd_r;
    assign app_wdf_data_o = data_r[int'(wbeat_r)*ui_data_width_p +: ui_data_width_p];
    assign app_wdf_mask_o = mask_r[int'(wbeat_r)*beat_mask_w_lp +: beat_mask_w_lp];
    assign rd_v_o         = (count_r != '0);
    assign rd_data_o      = rd_v_o ? mem[rptr_r] : '0;
    assign error_o        = error_r;

    always_comb begin
        state_n        = state_r;
        cmd_ready_o    = 1'b0;
        app_en_o       = 1'b0;
        app_wdf_wren_o = 1'b0;
        app_wdf_end_o  = 1'b0;
        case (state_r)
            IDLE: begin
                cmd_ready_o = ~reset_i & init_calib_complete_i & (credits_r != '0);
                if (cmd_v_i & cmd_ready_o) begin
`ifdef BSG_DMC_UI_BURST_ADAPTER_WDATA_FIRST_EN
                    state_n = cmd_write_i ? WDATA : CMD;
`else
                    state_n = CMD;
`endif
                end
            end
            CMD: begin
                app_en_o = 1'b1;
                if (app_rdy_i) begin
`ifdef BSG_DMC_UI_BURST_ADAPTER_WDATA_FIRST_EN
                    state_n = IDLE;
`else
                    state_n = (cmd_r == app_write_lp) ? WDATA : IDLE;
`endif
                end
            end
            WDATA: begin
                app_wdf_wren_o = 1'b1;
                app_wdf_end_o  = (wbeat_r == last_beat_lp);
                if (app_wdf_rdy_i & app_wdf_end_o) begin
`ifdef BSG_DMC_UI_BURST_ADAPTER_WDATA_FIRST_EN
                    state_n = CMD;
`else
                    state_n = IDLE;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            addr_r  <= '0;
            cmd_r   <= app_write_lp;
            data_r  <= '0;
            mask_r  <= '0;
            wbeat_r <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                addr_r <= cmd_addr_i;
                cmd_r  <= cmd_write_i ? app_write_lp : app_read_lp;
                data_r <= cmd_data_i;
                mask_r <= cmd_mask_i;
            end
            if (wdf_hs)
                wbeat_r <= (wbeat_r == last_beat_lp) ? '0 : wbeat_r + 1'b1;
        end
    end

    // Credits reserve a FIFO slot at read issue, so returning data always has room.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credits_r     <= max_credits_lp;
            outstanding_r <= '0;
            rbeat_r       <= '0;
            count_r       <= '0;
            wptr_r        <= '0;
            rptr_r        <= '0;
            error_r       <= 1'b0;
        end else begin
            case ({read_issue, pop})
                2'b10:   credits_r <= credits_r - 1'b1;
                2'b01:   credits_r <= credits_r + 1'b1;
                default: credits_r <= credits_r;
            endcase
            case ({read_issue, push & (outstanding_r != '0)})
                2'b10:   outstanding_r <= outstanding_r + 1'b1;
                2'b01:   outstanding_r <= outstanding_r - 1'b1;
                default: outstanding_r <= outstanding_r;
            endcase
            if (app_rd_data_valid_i)
                rbeat_r <= beat_last ? '0 : rbeat_r + 1'b1;
            case ({fifo_write, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (fifo_write)
                wptr_r <= next_ptr(wptr_r);
            if (pop)
                rptr_r <= next_ptr(rptr_r);
            if (err_cond)
                error_r <= 1'b1;
        end
    end

    // Data-only storage; validity is tracked by rbeat_r and count_r, which reset.
    always_ff @(posedge clk_i) begin
        if (app_rd_data_valid_i)
            asm_r[int'(rbeat_r)*ui_data_width_p +: ui_data_width_p] <= app_rd_data_i;
        if (fifo_write)
            mem[wptr_r] <= push_data;
    end

    always_comb begin
        push_data = asm_r;
        push_data[(ui_burst_length_p-1)*ui_data_width_p +: ui_data_width_p] = app_rd_data_i;
    end

endmodule

// File: tb/tb_bsg_dmc_ui_burst_adapter.sv
// Directed bench for bsg_dmc_ui_burst_adapter (default 28/32/8/4 configuration).
module tb_bsg_dmc_ui_burst_adapter;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int BL = 8;
    localparam int EL = 4;
    localparam int BW = DW * BL;
    localparam int MW = BW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_calib;
    logic          cmd_v, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_data;
    logic [MW-1:0] cmd_mask;
    logic          rd_v, rd_yumi;
    logic [BW-1:0] rd_data;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_rdy;
    logic          wren, wend, wdf_rdy;
    logic [DW-1:0] wdata;
    logic [3:0]    wmask;
    logic          rdv, rdend;
    logic [DW-1:0] rdbeat;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    bsg_dmc_ui_burst_adapter dut (
        .clk_i                 (clk),
        .reset_i               (rst),
        .init_calib_complete_i (init_calib),
        .cmd_v_i               (cmd_v),
        .cmd_ready_o           (cmd_ready),
        .cmd_write_i           (cmd_write),
        .cmd_addr_i            (cmd_addr),
        .cmd_data_i            (cmd_data),
        .cmd_mask_i            (cmd_mask),
        .rd_v_o                (rd_v),
        .rd_data_o             (rd_data),
        .rd_yumi_i             (rd_yumi),
        .app_addr_o            (app_addr),
        .app_cmd_o             (app_cmd),
        .app_en_o              (app_en),
        .app_rdy_i             (app_rdy),
        .app_wdf_wren_o        (wren),
        .app_wdf_data_o        (wdata),
        .app_wdf_mask_o        (wmask),
        .app_wdf_end_o         (wend),
        .app_wdf_rdy_i         (wdf_rdy),
        .app_rd_data_valid_i   (rdv),
        .app_rd_data_i         (rdbeat),
        .app_rd_data_end_i     (rdend),
        .error_o               (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [259:0] got, input logic [259:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_beat_val(input int b, input int k);
        return 32'hB000_0000 | (32'(b) << 8) | 32'(k);
    endfunction

    function automatic logic [BW-1:0] rd_burst_val(input int b);
        logic [BW-1:0] v;
        for (int k = 0; k < BL; k++) v[k*DW +: DW] = rd_beat_val(b, k);
        return v;
    endfunction

    task automatic pulse_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] base);
        int  k = 0, en_cnt = 0, en_hs = -1, first_en = -1, first_w = -1, last_w = -1;
        logic done = 1'b0;
        logic en, wr, order;
        check("wr_ready", cmd_ready, 1'b1);
        cmd_v = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_mask = '0;
        for (int i = 0; i < BL; i++) cmd_data[i*DW +: DW] = base | 32'(i);
        @(negedge clk);
        cmd_v = 1'b0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            en = app_en;
            wr = wren;
            app_rdy = en && (en_cnt >= 3);
            wdf_rdy = cyc[0];
            if (en) begin
                if (first_en < 0) first_en = cyc;
                en_cnt++;
            end
            if (en && app_rdy) begin
                en_hs = cyc;
                check("wr_cmd", {app_addr, app_cmd}, {a, 3'b000});
            end
            if (wr && wdf_rdy) begin
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
                check("wr_beat", {wend, wmask, wdata}, {k == BL-1, 4'h0, base | 32'(k)});
                k++;
            end
            @(negedge clk);
            done = (en_hs >= 0) && (k == BL);
        end
        app_rdy = 1'b0;
        wdf_rdy = 1'b0;
        check("wr_done", done, 1'b1);
        check("wr_en_held", en_cnt, 4);
`ifdef BSG_DMC_UI_BURST_ADAPTER_WDATA_FIRST_EN
        order = (last_w >= 0) && (first_en > last_w);
`else
        order = (en_hs >= 0) && (first_w > en_hs);
`endif
        check("wr_order", order, 1'b1);
        check("wr_idle_ready", cmd_ready, 1'b1);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        check("rd_ready", cmd_ready, 1'b1);
        cmd_v = 1'b1; cmd_write = 1'b0; cmd_addr = a;
        @(negedge clk);
        cmd_v = 1'b0;
        app_rdy = 1'b1;
        check("rd_cmd", {app_en, app_addr, app_cmd}, {1'b1, a, 3'b001});
        @(negedge clk);
        app_rdy = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic e);
        rdv = 1'b1; rdbeat = d; rdend = e;
        @(negedge clk);
        rdv = 1'b0; rdend = 1'b0;
    endtask

    initial begin
        logic hit;
        rst = 1'b1; init_calib = 1'b0; cmd_v = 1'b1; cmd_write = 1'b0;
        cmd_addr = '0; cmd_data = '0; cmd_mask = '0; rd_yumi = 1'b0;
        app_rdy = 1'b0; wdf_rdy = 1'b0; rdv = 1'b0; rdbeat = '0; rdend = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", {cmd_ready, app_en, wren, wend, error, rd_v, app_cmd}, '0);
        cmd_v = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        init_calib = 1'b1;
        @(negedge clk);

        do_write(28'h100, 32'hA000_0000);
        check("wr_no_error", error, 1'b0);

        for (int b = 0; b < EL; b++) do_read(28'h400 + 28'(b * 8));
        check("credits_exhausted", cmd_ready, 1'b0);

        for (int b = 0; b < EL; b++)
            for (int k = 0; k < BL; k++) send_beat(rd_beat_val(b, k), k == BL-1);
        check("rd_v_after_return", rd_v, 1'b1);
        check("rd_no_error", error, 1'b0);
        for (int b = 0; b < EL; b++) begin
            check("rd_burst", rd_data, rd_burst_val(b));
            rd_yumi = 1'b1;
            @(negedge clk);
            rd_yumi = 1'b0;
            if (b == 0) check("ready_after_yumi", cmd_ready, 1'b1);
        end
        check("rd_fifo_empty", rd_v, 1'b0);

        send_beat(32'hDEAD_0000, 1'b0);
        check("err_no_outstanding", error, 1'b1);
        repeat (3) @(negedge clk);
        check("err_sticky", error, 1'b1);
        pulse_reset();
        check("err_cleared", error, 1'b0);

        do_read(28'h500);
        for (int k = 0; k < 3; k++) send_beat(rd_beat_val(7, k), 1'b0);
        check("err_before_bad_end", error, 1'b0);
        send_beat(rd_beat_val(7, 3), 1'b1);
        check("err_early_end", error, 1'b1);
        pulse_reset();

        cmd_v = 1'b1; cmd_write = 1'b1; cmd_addr = 28'h300; cmd_mask = '0;
        for (int i = 0; i < BL; i++) cmd_data[i*DW +: DW] = 32'hC000_0000 | 32'(i);
        @(negedge clk);
        cmd_v = 1'b0; app_rdy = 1'b1; wdf_rdy = 1'b1;
        hit = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (wren && wdata == 32'hC000_0004) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reached_beat4", hit, 1'b1);
        #1 rst = 1'b1;
        #1 check("rst_async_outs", {wren, app_en, wend, cmd_ready, error, rd_v, app_cmd}, '0);
        @(negedge clk);
        rst = 1'b0; app_rdy = 1'b0; wdf_rdy = 1'b0;
        @(negedge clk);
        do_write(28'h180, 32'hD000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
